// File: rtl/qtpa_pkg.sv
// -----------------------------------------------------------------------------
// qtpa_pkg
//
// Purpose:
//   Shared ISA-level definitions for the scalar front end: the instruction
//   width, the opcode field location and encoding, and the instruction
//   formats. The scalar instruction queue state type is also kept here.
//
// Contents:
//   INSTRUCTION_WIDTH   width of one instruction word
//   OPCODE_MSB/LSB      bit range of the opcode field, shared with decode
//   op_t                opcode encoding (HALT stops issue at the queue)
//   instr_i_t/instr_r_t immediate and register instruction formats
//   iq_state_t          run/halted state of the scalar instruction queue
//   get_opcode()        extracts the opcode field from a raw word
// -----------------------------------------------------------------------------
package qtpa_pkg;

    localparam int INSTRUCTION_WIDTH = 32;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int OPCODE_W   = OPCODE_MSB - OPCODE_LSB + 1;

    typedef enum logic [OPCODE_W-1:0] {
        NOP     = 6'h00,
        ADD_IMM = 6'h01,
        MOV_IMM = 6'h02,
        BRANCH  = 6'h03,
        LOOP    = 6'h04,
        YIELD   = 6'h05,
        HALT    = 6'h3F
    } op_t;

    // Immediate format: opcode plus a 26-bit immediate payload.
    typedef struct packed {
        op_t         opcode;
        logic [25:0] imm;
    } instr_i_t;

    // Register format: opcode, three register specifiers, reserved tail.
    typedef struct packed {
        op_t         opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [10:0] rsvd;
    } instr_r_t;

    typedef enum logic {
        IQ_RUN,
        IQ_HALTED
    } iq_state_t;

    function automatic op_t get_opcode(input logic [INSTRUCTION_WIDTH-1:0] word);
        return op_t'(word[OPCODE_MSB:OPCODE_LSB]);
    endfunction

endpackage : qtpa_pkg

// File: rtl/scalar_iq.sv
// -----------------------------------------------------------------------------
// scalar_iq  (IQ0)
//
// Purpose:
//   Scalar instruction queue between fetch and scalar decode. A circular FIFO
//   of DEPTH instruction words with first-word-fall-through output. A HALT
//   word leaving the queue freezes issue until resume; flush empties the
//   queue without touching the run/halted state.
//
// Ports:
//   clk        core clock
//   rst        synchronous active-high reset
//   in_valid   fetch presents in_instr
//   in_ready   queue accepts in_instr this cycle (never while full/flush/rst)
//   in_instr   instruction word from fetch
//   out_valid  head word available to decode (only while running)
//   out_ready  decode consumes the head this cycle
//   out_instr  head word, all-zero whenever out_valid is low
//   flush      discard every queued word
//   resume     leave the halted state
//   halted     queue is halted
//   count      current occupancy, 0..DEPTH
//   full       count == DEPTH
//   empty      count == 0
// -----------------------------------------------------------------------------
module scalar_iq
    import qtpa_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                         clk,
    input  logic                         rst,

    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [INSTRUCTION_WIDTH-1:0] in_instr,

    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [INSTRUCTION_WIDTH-1:0] out_instr,

    input  logic                         flush,
    input  logic                         resume,
    output logic                         halted,

    output logic [CNT_W-1:0]             count,
    output logic                         full,
    output logic                         empty
);

    localparam int PTR_W = $clog2(DEPTH);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [INSTRUCTION_WIDTH-1:0] mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    iq_state_t        state_q;

    logic enq;
    logic deq;
    logic head_is_halt;

    // -------------------------------------------------------------------------
    // Status and handshakes
    // -------------------------------------------------------------------------
    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

    // Deliberately independent of out_ready: a full queue never accepts a
    // word, even when the head leaves in the same cycle.
    assign in_ready = !full && !flush && !rst;

    assign out_valid = !empty && (state_q == IQ_RUN);
    assign out_instr = out_valid ? mem[rd_ptr_q] : '0;
    assign halted    = (state_q == IQ_HALTED);

    assign enq = in_valid && in_ready;
    // A flush cancels the consume even though decode saw out_valid high.
    assign deq = out_valid && out_ready && !flush;

    assign head_is_halt = (get_opcode(out_instr) == HALT);

    // -------------------------------------------------------------------------
    // Pointer / occupancy next state
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (enq) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (deq) rd_ptr_d = rd_ptr_q + PTR_W'(1);

            unique case ({enq, deq})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // -------------------------------------------------------------------------
    // Run / halted state machine
    // -------------------------------------------------------------------------
    // The HALT word is consumed like any other; issue stops only afterwards.
    // Flush never changes the state: it suppresses deq, so no HALT is seen.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IQ_RUN;
        end else begin
            unique case (state_q)
                IQ_RUN:    if (deq && head_is_halt) state_q <= IQ_HALTED;
                IQ_HALTED: if (resume)              state_q <= IQ_RUN;
                default:                            state_q <= IQ_RUN;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Storage
    // -------------------------------------------------------------------------
    // NOTE: the array is intentionally not reset; count and pointers alone
    // define which entries are live, so stale contents are never visible.
    always_ff @(posedge clk) begin
        if (enq) mem[wr_ptr_q] <= in_instr;
    end

    // -------------------------------------------------------------------------
    // Invariants
    // -------------------------------------------------------------------------
    // Occupancy matches the pointer distance modulo DEPTH; a full queue has
    // equal pointers and its count wraps to zero in the low bits.
    a_count_matches_ptrs: assert property (@(posedge clk) disable iff (rst)
        count_q[PTR_W-1:0] == PTR_W'(wr_ptr_q - rd_ptr_q));

    a_count_bounded: assert property (@(posedge clk) disable iff (rst)
        count_q <= CNT_W'(DEPTH));

    a_head_stable: assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready && !flush) |=> (out_instr == $past(out_instr)));

endmodule : scalar_iq

// File: tb/tb_scalar_iq.sv
// -----------------------------------------------------------------------------
// tb_scalar_iq
//
// Directed stimulus for the scalar instruction queue. A queue-based reference
// model tracks the expected contents and halted flag; every negative clock
// edge all outputs are compared against it. Directed literal checks pin the
// model at the interesting points of each scenario.
// -----------------------------------------------------------------------------
module tb_scalar_iq;
    import qtpa_pkg::*;

    localparam int DEPTH = 8;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                         clk = 1'b0;
    logic                         rst;
    logic                         in_valid;
    logic                         in_ready;
    logic [INSTRUCTION_WIDTH-1:0] in_instr;
    logic                         out_valid;
    logic                         out_ready;
    logic [INSTRUCTION_WIDTH-1:0] out_instr;
    logic                         flush;
    logic                         resume;
    logic                         halted;
    logic [CNT_W-1:0]             count;
    logic                         full;
    logic                         empty;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    scalar_iq #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .flush     (flush),
        .resume    (resume),
        .halted    (halted),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    always #5 clk = ~clk;

    // -------------------------------------------------------------------------
    // Reference model: a plain queue of words plus a halted flag.
    // -------------------------------------------------------------------------
    logic [31:0] mq[$];
    bit          m_halted = 1'b0;

    function automatic bit m_in_ready();
        return !rst && !flush && (mq.size() < DEPTH);
    endfunction

    function automatic bit m_out_valid();
        return (mq.size() != 0) && !m_halted;
    endfunction

    function automatic logic [31:0] m_out_instr();
        return m_out_valid() ? mq[0] : 32'h0;
    endfunction

    always @(posedge clk) begin
        bit          was_halted;
        bit          do_enq;
        bit          do_deq;
        logic [31:0] w;
        was_halted = m_halted;
        if (rst) begin
            mq.delete();
            m_halted = 1'b0;
        end else begin
            if (flush) begin
                mq.delete();
            end else begin
                do_deq = m_out_valid() && out_ready;
                do_enq = in_valid && m_in_ready();
                if (do_deq) begin
                    w = mq.pop_front();
                    if (w[31:26] == 6'h3F) m_halted = 1'b1;
                end
                if (do_enq) mq.push_back(in_instr);
            end
            if (was_halted && resume) m_halted = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Checking
    // -------------------------------------------------------------------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("m_count",     32'(count),     32'(mq.size()));
            check("m_empty",     32'(empty),     32'(mq.size() == 0));
            check("m_full",      32'(full),      32'(mq.size() == DEPTH));
            check("m_in_ready",  32'(in_ready),  32'(m_in_ready()));
            check("m_out_valid", 32'(out_valid), 32'(m_out_valid()));
            check("m_out_instr", out_instr,      m_out_instr());
            check("m_halted",    32'(halted),    32'(m_halted));
        end
    end

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] w);
        in_valid = 1'b1;
        in_instr = w;
        step();
        in_valid = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_instr  = '0;
        out_ready = 1'b0;
        flush     = 1'b0;
        resume    = 1'b0;

        // Reset
        step();
        chk_en = 1'b1;
        step();
        check("in_ready_in_rst", 32'(in_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("rst_count",     32'(count),     32'd0);
        check("rst_empty",     32'(empty),     32'd1);
        check("rst_full",      32'(full),      32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_instr", out_instr,      32'h0);
        check("rst_halted",    32'(halted),    32'd0);

        // Three pushes with decode stalled
        in_valid = 1'b1;
        in_instr = 32'h0400_0001;
        step();
        check("first_vis_valid", 32'(out_valid), 32'd1);
        check("first_vis_instr", out_instr,      32'h0400_0001);
        in_instr = 32'h0400_0002;
        step();
        in_instr = 32'h0400_0003;
        step();
        in_valid = 1'b0;
        check("push3_count", 32'(count), 32'd3);
        step();
        step();
        check("push3_head_stable", out_instr, 32'h0400_0001);

        // Fill to DEPTH, then a 9th word must be refused
        for (int i = 0; i < 5; i++) push(32'h0400_0010 + 32'(i));
        check("fill_full",     32'(full),     32'd1);
        check("fill_count",    32'(count),    32'd8);
        check("fill_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b1;
        in_instr = 32'h0400_DEAD;
        step();
        check("ninth_dropped", 32'(count), 32'd8);
        out_ready = 1'b1;
        #1;
        check("full_deq_no_bypass", 32'(in_ready), 32'd0);
        step();
        check("full_deq_count", 32'(count), 32'd7);
        step();
        check("refill_count", 32'(count), 32'd7);
        for (int i = 0; i < 3; i++) begin
            in_instr = 32'h0400_0020 + 32'(i);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;

        // Streaming at count=4 across pointer wrap
        do_flush();
        check("flush_stream_count", 32'(count), 32'd0);
        for (int k = 0; k < 4; k++) push(32'h0400_0100 + 32'(k));
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int k = 4; k < 24; k++) begin
            in_instr = 32'h0400_0100 + 32'(k);
            step();
        end
        check("stream_count", 32'(count), 32'd4);
        check("stream_head",  out_instr,  32'h0400_0114);
        in_valid  = 1'b0;
        out_ready = 1'b0;

        // HALT handling
        do_flush();
        push(32'h0400_0AAA);  // ADD_IMM
        push(32'hFC00_0055);  // HALT
        push(32'h0800_0BBB);  // MOV_IMM
        out_ready = 1'b1;
        step();
        check("halt_pre_head", out_instr, 32'hFC00_0055);
        step();
        check("halt_halted",    32'(halted),    32'd1);
        check("halt_out_valid", 32'(out_valid), 32'd0);
        check("halt_count",     32'(count),     32'd1);
        step();
        check("halt_hold_count", 32'(count), 32'd1);
        resume = 1'b1;
        step();
        resume = 1'b0;
        check("resume_halted", 32'(halted),    32'd0);
        check("resume_valid",  32'(out_valid), 32'd1);
        check("resume_instr",  out_instr,      32'h0800_0BBB);
        out_ready = 1'b0;

        // Flush with count=5 and a simultaneous push
        do_flush();
        for (int i = 0; i < 5; i++) push(32'h0400_0300 + 32'(i));
        check("pre_flush_count", 32'(count), 32'd5);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_instr = 32'h0400_BEEF;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_count", 32'(count), 32'd0);
        check("flush_empty", 32'(empty), 32'd1);

        // Flush while halted keeps the halted state
        push(32'hFC00_0001);
        for (int i = 1; i < 4; i++) push(32'h0400_0200 + 32'(i));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("halt2_halted", 32'(halted), 32'd1);
        check("halt2_count",  32'(count),  32'd3);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_instr = 32'h0400_CAFE;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("hflush_count",  32'(count),  32'd0);
        check("hflush_halted", 32'(halted), 32'd1);

        // Enqueue while halted, then reset mid-operation
        for (int i = 0; i < 6; i++) push(32'h0400_0400 + 32'(i));
        check("halted_enq_count", 32'(count),     32'd6);
        check("halted_no_issue",  32'(out_valid), 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("mrst_count",     32'(count),     32'd0);
        check("mrst_halted",    32'(halted),    32'd0);
        check("mrst_in_ready",  32'(in_ready),  32'd1);
        check("mrst_out_valid", 32'(out_valid), 32'd0);

        // Resume while running is ignored
        push(32'h0C00_0077);  // BRANCH passes through untouched
        resume = 1'b1;
        step();
        resume = 1'b0;
        check("run_resume_halted", 32'(halted),    32'd0);
        check("run_resume_valid",  32'(out_valid), 32'd1);
        check("run_resume_instr",  out_instr,      32'h0C00_0077);
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_scalar_iq
